// File: rtl/umi_pkg.sv
// Shared UMI definitions: command field layout, header slot positions,
// the packer FSM state type and a command builder.
package umi_pkg;

    localparam int UMI_CMD_W  = 32;
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_W   = 8;
    localparam int SIZE_LSB   = 8;
    localparam int SIZE_W     = 4;
    localparam int USER_LSB   = 12;
    localparam int USER_W     = 20;

    // Opcode value decoded as a read request.
    localparam logic [OPCODE_W-1:0] UMI_OP_READ = 8'h02;

    // Data is rotated by this many bits to open the header slots at the bottom.
    localparam int UMI_ROT     = 96;
    localparam int HDR_CMD_LSB = 0;
    localparam int HDR_DST_LSB = 32;
    localparam int HDR_SRC_LSB = 64;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    function automatic logic [UMI_CMD_W-1:0] umi_cmd(
        input logic [OPCODE_W-1:0] opcode,
        input logic [SIZE_W-1:0]   size,
        input logic [USER_W-1:0]   user
    );
        return {user, size, opcode};
    endfunction

endpackage

// File: rtl/umi_decode.sv
// UMI command decoder.
// Ports: cmd (32-bit command word) -> cmd_read (command is a read request).
module umi_decode
    import umi_pkg::*;
(
    input  logic [UMI_CMD_W-1:0] cmd,
    output logic                 cmd_read
);

    // Only the opcode matters for the read decode; size/user are ignored.
    logic unused_fields;

    assign cmd_read      = (cmd[OPCODE_LSB +: OPCODE_W] == UMI_OP_READ);
    assign unused_fields = ^cmd[UMI_CMD_W-1:OPCODE_W];

endmodule

// File: rtl/umi_pack_fifo.sv
// Synchronous FIFO with an explicit occupancy count.
// Ports: clk, reset (async, active high), push/push_data/full on the write
// side, pop/pop_data/empty on the read side. pop_data shows the head entry.
// Push while full and pop while empty are ignored.
module umi_pack_fifo #(
    parameter int DW    = 257,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    output logic          full,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [DW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push, do_pop;

    assign full     = (count == CNT_MAX);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/umi_pack_stream.sv
// Streaming UMI packer. A transaction arrives as a valid/ready beat stream
// (header beat first, then burst data); each beat becomes one formatted UMI
// packet in a DEPTH-entry output FIFO.
// Ports: clk, reset; in_* beat stream with header fields; out_valid/out_ready/
// out_packet/out_last packet stream; err_clear/err_overrun sticky error for a
// transaction that reached MAXBEATS without in_last.
module umi_pack_stream
    import umi_pkg::*;
#(
    parameter int AW       = 64,
    parameter int PW       = 256,
    parameter int DEPTH    = 4,
    parameter int MAXBEATS = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_opcode,
    input  logic [3:0]    in_size,
    input  logic [19:0]   in_user,
    input  logic [AW-1:0] in_dstaddr,
    input  logic [AW-1:0] in_srcaddr,
    input  logic [PW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_packet,
    output logic          out_last,
    input  logic          err_clear,
    output logic          err_overrun
);

    localparam int CNT_W = $clog2(MAXBEATS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAXBEATS - 1);

    state_t               state;
    logic [CNT_W-1:0]     beat_cnt;
    logic [UMI_CMD_W-1:0] cmd;
    logic                 cmd_read;
    logic [63:0]          dst64, src64;
    logic [PW-1:0]        rot, hdr;
    logic                 in_fire, overrun, push_last, full, empty;

    assign cmd   = umi_cmd(in_opcode, in_size, in_user);
    assign dst64 = 64'(in_dstaddr);
    assign src64 = 64'(in_srcaddr);
    assign rot   = {in_data[PW-UMI_ROT-1:0], in_data[PW-1:PW-UMI_ROT]};

    umi_decode u_decode (
        .cmd      (cmd),
        .cmd_read (cmd_read)
    );

    always_comb begin
        hdr = rot;
        hdr[HDR_CMD_LSB +: 32] = cmd;
        hdr[HDR_DST_LSB +: 32] = dst64[31:0];
        hdr[HDR_SRC_LSB +: 32] = src64[31:0];
        if (AW == 64) begin
            hdr[PW-1 -: 32] = dst64[63:32];
            if (cmd_read) hdr[PW-33 -: 32] = src64[63:32];
        end
    end

    // No pass-through path: a full buffer stalls input regardless of out_ready.
    assign in_ready = !full && !reset;
    assign in_fire  = in_valid && in_ready;

    // Compared against the pre-increment count: the beat that would be the
    // MAXBEATS-th of the transaction is forced to close it.
    assign overrun   = (state == BURST) && !in_last && (beat_cnt == LAST_CNT);
    assign push_last = in_last || overrun;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            err_overrun <= 1'b0;
        end else begin
            if (in_fire) begin
                if (state == IDLE) begin
                    if (!in_last) begin
                        state    <= BURST;
                        beat_cnt <= CNT_ONE;
                    end
                end else if (push_last) begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + CNT_ONE;
                end
            end
            if (in_fire && overrun) err_overrun <= 1'b1;
            else if (err_clear)     err_overrun <= 1'b0;
        end
    end

    umi_pack_fifo #(
        .DW    (PW + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_fire),
        .push_data ({push_last, (state == IDLE) ? hdr : rot}),
        .full      (full),
        .pop       (out_valid && out_ready),
        .pop_data  ({out_last, out_packet}),
        .empty     (empty)
    );

    assign out_valid = !empty;

endmodule

// File: tb/tb_umi_pack_stream.sv
module tb_umi_pack_stream;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready;
    logic [7:0]   in_opcode;
    logic [3:0]   in_size;
    logic [19:0]  in_user;
    logic [63:0]  in_dstaddr, in_srcaddr;
    logic [255:0] in_data;
    logic         in_last;
    logic         out_valid, out_ready;
    logic [255:0] out_packet;
    logic         out_last;
    logic         err_clear, err_overrun;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    umi_pack_stream #(.AW(64), .PW(256), .DEPTH(4), .MAXBEATS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_size     (in_size),
        .in_user     (in_user),
        .in_dstaddr  (in_dstaddr),
        .in_srcaddr  (in_srcaddr),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_packet  (out_packet),
        .out_last    (out_last),
        .err_clear   (err_clear),
        .err_overrun (err_overrun)
    );

    typedef struct {
        logic [7:0]   op;
        logic [3:0]   size;
        logic [19:0]  user;
        logic [63:0]  dst;
        logic [63:0]  src;
        logic [255:0] data;
        logic [255:0] exp;
    } vec_t;

    vec_t vt [4];

    localparam logic [63:0] DST = 64'h11112222_33334444;
    localparam logic [63:0] SRC = 64'h55556666_77778888;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    // Write header (opcode 0x01, size 0, user 0, DST/SRC) built from replicated data word w.
    function automatic logic [255:0] hdr_wr(input logic [31:0] w);
        return {32'h11112222, w, w, w, w, 32'h77778888, 32'h33334444, 32'h00000001};
    endfunction

    task automatic beat(input logic [7:0] op, input logic [3:0] sz, input logic [19:0] us,
                        input logic [63:0] d, input logic [63:0] s,
                        input logic [255:0] dat, input logic lst);
        in_valid   = 1'b1;
        in_opcode  = op;
        in_size    = sz;
        in_user    = us;
        in_dstaddr = d;
        in_srcaddr = s;
        in_data    = dat;
        in_last    = lst;
        @(negedge clk);
    endtask

    initial begin
        logic [255:0] exp_pkt [6];
        logic         exp_lst [6];
        logic [255:0] held;

        vt[0] = '{8'h01, 4'h0, 20'h00000, DST, SRC,
                  256'hD0000007_D0000006_D0000005_D0000004_D0000003_D0000002_D0000001_D0000000,
                  256'h11112222_D0000003_D0000002_D0000001_D0000000_77778888_33334444_00000001};
        vt[1] = '{8'h02, 4'h3, 20'hABCDE, DST, SRC,
                  256'hD0000007_D0000006_D0000005_D0000004_D0000003_D0000002_D0000001_D0000000,
                  256'h11112222_55556666_D0000002_D0000001_D0000000_77778888_33334444_ABCDE302};
        vt[2] = '{8'h03, 4'h5, 20'h00001, 64'h0, 64'hFFFFFFFF_FFFFFFFF, 256'h0,
                  256'h00000000_00000000_00000000_00000000_00000000_FFFFFFFF_00000000_00001503};
        vt[3] = '{8'h02, 4'h0, 20'h00000, 64'hFFFFFFFF_00000000, 64'h12345678_9ABCDEF0, 256'h0,
                  256'hFFFFFFFF_12345678_00000000_00000000_00000000_9ABCDEF0_00000000_00000002};

        reset = 1'b1; in_valid = 1'b0; in_opcode = '0; in_size = '0; in_user = '0;
        in_dstaddr = '0; in_srcaddr = '0; in_data = '0; in_last = 1'b0;
        out_ready = 1'b1; err_clear = 1'b0;

        // Reset state
        #3;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_packet", out_packet, 0);
        chk("rst_err", err_overrun, 0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // Single-beat transactions from the table
        for (int i = 0; i < 4; i++) begin
            beat(vt[i].op, vt[i].size, vt[i].user, vt[i].dst, vt[i].src, vt[i].data, 1'b1);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_packet", i), out_packet, vt[i].exp);
            chk($sformatf("vec%0d_last", i), out_last, 1);
            @(negedge clk);
            chk($sformatf("vec%0d_drained", i), out_valid, 0);
        end

        // 4-beat burst, header fields scrambled on burst beats
        for (int k = 0; k < 4; k++) begin
            if (k == 0) beat(8'h01, 4'h0, 20'h0, DST, SRC, {8{32'(k)}}, 1'b0);
            else        beat(8'h02, 4'hF, 20'hFFFFF, 64'hDEAD, 64'hBEEF, {8{32'(k)}}, k == 3);
            chk($sformatf("burst%0d_packet", k), out_packet, (k == 0) ? hdr_wr(32'h0) : {8{32'(k)}});
            chk($sformatf("burst%0d_last", k), out_last, k == 3);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("burst_drained", out_valid, 0);
        chk("burst_no_err", err_overrun, 0);

        // Back-pressure: fill all entries, hold an extra beat, then drain
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            beat(8'h01, 4'h0, 20'h0, DST, SRC, {8{32'hA0 + 32'(k)}}, k == 3);
            exp_pkt[k] = (k == 0) ? hdr_wr(32'hA0) : {8{32'hA0 + 32'(k)}};
        end
        chk("bp_full_in_ready", in_ready, 0);
        held = out_packet;
        chk("bp_head", held, exp_pkt[0]);
        in_valid = 1'b1; in_data = {8{32'hFF}}; in_last = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("bp_stable%0d", c), out_packet, exp_pkt[0]);
            chk($sformatf("bp_blocked%0d", c), in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d_packet", k), out_packet, exp_pkt[k]);
            chk($sformatf("drain%0d_last", k), out_last, k == 3);
            @(negedge clk);
        end
        chk("drain_empty", out_valid, 0);

        // Overrun with MAXBEATS=4: 6 beats, in_last only on the 6th
        for (int k = 0; k < 6; k++) begin
            exp_pkt[k] = {8{32'hC0 + 32'(k)}};
            exp_lst[k] = (k == 3) || (k == 5);
        end
        exp_pkt[0] = hdr_wr(32'hC0);
        exp_pkt[4] = hdr_wr(32'hC4);
        for (int k = 0; k < 6; k++) begin
            beat(8'h01, 4'h0, 20'h0, DST, SRC, {8{32'hC0 + 32'(k)}}, k == 5);
            chk($sformatf("ovr%0d_packet", k), out_packet, exp_pkt[k]);
            chk($sformatf("ovr%0d_last", k), out_last, exp_lst[k]);
            if (k == 2) chk("ovr_err_before", err_overrun, 0);
            if (k == 3) chk("ovr_err_set", err_overrun, 1);
        end
        in_valid = 1'b0;
        chk("ovr_err_sticky", err_overrun, 1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("ovr_err_cleared", err_overrun, 0);

        // Reset mid-burst with 3 packets buffered
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) beat(8'h01, 4'h0, 20'h0, DST, SRC, {8{32'h50 + 32'(k)}}, 1'b0);
        in_valid = 1'b0;
        chk("mid_buffered", out_valid, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_packet", out_packet, 0);
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b1;
        beat(8'h01, 4'h0, 20'h0, DST, SRC, {8{32'hEE}}, 1'b1);
        in_valid = 1'b0;
        chk("after_rst_header", out_packet, hdr_wr(32'hEE));
        chk("after_rst_last", out_last, 1);
        @(negedge clk);
        chk("after_rst_drained", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
